load_store_unit: RTL

- Sits between the single-cycle core's execute stage and data_memory. Translates core load/store requests (funct3, byte address, store data) into word address, byte mask, lane-aligned write data, and sign/zero-extended load data.
- Misaligned accesses that cross a word boundary are split into two aligned data_memory accesses over two cycles. The core is stalled for the first cycle.

---
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between the core execute stage and data_memory.
// Word-crossing accesses are split into two aligned memory accesses, and the core is stalled for the first one.
module load_store_unit #(
    parameter int DMEM_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [DMEM_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              err,
    output logic [DMEM_W-1:0] mem_addr,
    output logic [3:0]        mem_bmask,
    output logic              mem_wr_en,
    output logic [31:0]       mem_w_data,
    input  logic [31:0]       mem_r_data
);

    // state  | meaning
    // IDLE   | ready; aligned accesses and first halves of split accesses
    // SECOND | issuing the upper-word half of a split access
    typedef enum logic {
        IDLE,
        SECOND
    } state_t;

    state_t state, state_next;

    logic [31:0]       lo_q;
    logic              lo_load;
    logic [DMEM_W-3:0] word;
    logic [DMEM_W-3:0] word_inc;
    logic [1:0]        offset;
    logic [2:0]        size;
    logic [3:0]        base_mask;
    logic              legal;
    logic              misaligned;
    logic [7:0]        bmask_wide;
    logic [63:0]       wdata_wide;
    logic [63:0]       load_src;
    logic [63:0]       load_shift;
    logic [31:0]       load_ext;

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] raw);
        logic [31:0] res;
        case (f3)
            3'b000:  res = {{24{raw[7]}}, raw[7:0]};
            3'b001:  res = {{16{raw[15]}}, raw[15:0]};
            3'b100:  res = {24'h0, raw[7:0]};
            3'b101:  res = {16'h0, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    assign word     = req_addr[DMEM_W-1:2];
    assign word_inc = word + 1'b1;    // wraps from the top word to word 0
    assign offset   = req_addr[1:0];

    always_comb begin
        size      = 3'd4;
        base_mask = 4'b1111;
        case (req_funct3[1:0])
            2'b00: begin
                size      = 3'd1;
                base_mask = 4'b0001;
            end
            2'b01: begin
                size      = 3'd2;
                base_mask = 4'b0011;
            end
            default: begin
                size      = 3'd4;
                base_mask = 4'b1111;
            end
        endcase
    end

    always_comb begin
        legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = ~req_we;
            default:                legal = 1'b0;
        endcase
    end

    assign misaligned = (({1'b0, offset} + size) > 3'd4);

    // Low byte lanes / low word belong to the first access, high ones to the second.
    assign bmask_wide = {4'b0000, base_mask} << offset;
    assign wdata_wide = {32'h0, req_wdata} << {offset, 3'b000};

    assign load_src   = (state == SECOND) ? {mem_r_data, lo_q} : {32'h0, mem_r_data};
    assign load_shift = load_src >> {offset, 3'b000};
    assign load_ext   = extend(req_funct3, load_shift[31:0]);

    always_comb begin
        state_next  = state;
        stall       = 1'b0;
        rdata       = 32'h0;
        rdata_valid = 1'b0;
        err         = 1'b0;
        mem_addr    = {word, 2'b00};
        mem_bmask   = 4'b0000;
        mem_wr_en   = 1'b0;
        mem_w_data  = wdata_wide[31:0];
        lo_load     = 1'b0;

        if (!rst) begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (!legal) begin
                            err = 1'b1;
                        end else begin
                            mem_bmask = bmask_wide[3:0];
                            mem_wr_en = req_we;
                            if (misaligned) begin
                                stall      = 1'b1;
                                lo_load    = ~req_we;
                                state_next = SECOND;
                            end else if (!req_we) begin
                                rdata       = load_ext;
                                rdata_valid = 1'b1;
                            end
                        end
                    end
                end
                SECOND: begin
                    // Always leave SECOND so a dropped or corrupted request cannot lock the unit.
                    state_next = IDLE;
                    mem_addr   = {word_inc, 2'b00};
                    mem_w_data = wdata_wide[63:32];
                    if (req_valid) begin
                        if (!legal) begin
                            err = 1'b1;
                        end else begin
                            mem_bmask = bmask_wide[7:4];
                            mem_wr_en = req_we;
                            if (!req_we) begin
                                rdata       = load_ext;
                                rdata_valid = 1'b1;
                            end
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            lo_q  <= 32'h0;
        end else begin
            state <= state_next;
            if (lo_load) begin
                lo_q <= mem_r_data;
            end
        end
    end

endmodule
